// File: rtl/mult_stage_pipe_pkg.sv
// Shared constants and helpers for the elastic inversion pipeline.
// Occupancy width and net polarity are derived here so callers agree on them.
package mult_stage_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 3;

  // Counter must hold 0..depth inclusive.
  function automatic int occ_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

  // Odd number of inverting stages means the word leaves inverted.
  function automatic logic net_inv(input logic [31:0] mask, input int depth);
    logic parity;
    parity = 1'b0;
    for (int i = 0; i < depth; i++) begin
      parity = parity ^ mask[i];
    end
    return parity;
  endfunction

endpackage

// File: rtl/mult_stage_pipe_stage.sv
// One elastic register slot: holds a word plus its valid bit, optionally inverting on load.
// Local ready lets an empty slot fill even while the slot downstream is stalled.
module mult_stage_pipe_stage
  import mult_stage_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter bit INV   = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic [WIDTH-1:0] up_data,
  input  logic             up_valid,
  input  logic             down_ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             ready
);

  assign ready = !valid | down_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (ready) begin
      valid <= up_valid;
      if (up_valid) begin
        data <= up_data ^ {WIDTH{INV}};
      end
    end
  end

endmodule

// File: rtl/mult_stage_pipe.sv
// Elastic DEPTH-stage inversion pipeline with bubble collapsing and synchronous flush.
// Optional occupancy counter is compiled in with MULT_STAGE_PIPE_OCC_EN.
module mult_stage_pipe
  import mult_stage_pipe_pkg::*;
#(
  parameter int               WIDTH    = DEFAULT_WIDTH,
  parameter int               DEPTH    = DEFAULT_DEPTH,
  parameter logic [DEPTH-1:0] INV_MASK = {DEPTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] source,
  input  logic             source_valid,
  output logic             source_ready,
  input  logic             flush,
  output logic [WIDTH-1:0] drain,
  output logic             drain_valid,
  input  logic             drain_ready
`ifdef MULT_STAGE_PIPE_OCC_EN
  ,
  output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

  // Handshake: a word moves across a port on a rising edge where valid and
  // ready are both high; valid never depends on ready, ready is combinational
  // back from drain_ready through every stage.
  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];
  logic             rdy         [DEPTH+1];

  assign rdy[DEPTH] = drain_ready;

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] up_data;
    logic             up_valid;

    if (i == 0) begin : g_head
      assign up_data  = source;
      assign up_valid = source_valid;
    end else begin : g_body
      assign up_data  = stage_data[i-1];
      assign up_valid = stage_valid[i-1];
    end

    mult_stage_pipe_stage #(
      .WIDTH (WIDTH),
      .INV   (INV_MASK[i])
    ) u_stage (
      .clk        (clk),
      .reset      (reset),
      .flush      (flush),
      .up_data    (up_data),
      .up_valid   (up_valid),
      .down_ready (rdy[i+1]),
      .data       (stage_data[i]),
      .valid      (stage_valid[i]),
      .ready      (rdy[i])
    );
  end

  assign source_ready = rdy[0] & !reset & !flush;
  assign drain        = stage_data[DEPTH-1];
  assign drain_valid  = stage_valid[DEPTH-1];

`ifdef MULT_STAGE_PIPE_OCC_EN
  localparam int OCC_W = occ_width(DEPTH);

  logic [OCC_W-1:0] occ_q;
  logic             push;
  logic             pop;

  assign push      = source_valid & source_ready;
  assign pop       = drain_valid & drain_ready;
  assign occupancy = occ_q;

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      occ_q <= '0;
    end else if (push && !pop) begin
      occ_q <= occ_q + OCC_W'(1);
    end else if (pop && !push) begin
      occ_q <= occ_q - OCC_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mult_stage_pipe.sv
// Bench for mult_stage_pipe: two instances (odd and even inversion masks) share one stimulus
// stream and are scored against a word-queue model of an order-preserving DEPTH-entry buffer.
module tb_mult_stage_pipe;

  localparam int         W      = 8;
  localparam int         D      = 3;
  localparam logic [2:0] MASK_A = 3'b111;
  localparam logic [2:0] MASK_B = 3'b011;

  function automatic bit odd_ones(input logic [2:0] m);
    int n;
    n = 0;
    for (int i = 0; i < 3; i++) n += int'(m[i]);
    return (n % 2) == 1;
  endfunction

  localparam bit INV_A = odd_ones(MASK_A);
  localparam bit INV_B = odd_ones(MASK_B);

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [W-1:0] source = '0;
  logic         source_valid = 1'b0;
  logic         flush = 1'b0;
  logic         drain_ready = 1'b0;

  logic         sr_a, sr_b, dv_a, dv_b;
  logic [W-1:0] drain_a, drain_b;
`ifdef MULT_STAGE_PIPE_OCC_EN
  logic [1:0]   occ_a, occ_b;
`endif

  always #5 clk = ~clk;

  mult_stage_pipe #(.WIDTH(W), .DEPTH(D), .INV_MASK(MASK_A)) dut_a (
    .clk          (clk),
    .reset        (reset),
    .source       (source),
    .source_valid (source_valid),
    .source_ready (sr_a),
    .flush        (flush),
    .drain        (drain_a),
    .drain_valid  (dv_a),
    .drain_ready  (drain_ready)
`ifdef MULT_STAGE_PIPE_OCC_EN
    ,
    .occupancy    (occ_a)
`endif
  );

  mult_stage_pipe #(.WIDTH(W), .DEPTH(D), .INV_MASK(MASK_B)) dut_b (
    .clk          (clk),
    .reset        (reset),
    .source       (source),
    .source_valid (source_valid),
    .source_ready (sr_b),
    .flush        (flush),
    .drain        (drain_b),
    .drain_valid  (dv_b),
    .drain_ready  (drain_ready)
`ifdef MULT_STAGE_PIPE_OCC_EN
    ,
    .occupancy    (occ_b)
`endif
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q_a[$];
  logic [W-1:0] exp_q_b[$];
  int n_chk = 0;
  int n_err = 0;

  logic         obs_dv, obs_sr;
  logic [W-1:0] obs_da, obs_db;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver + model, one clock cycle per call ----------------
  task automatic step(input logic sv, input logic [W-1:0] sd, input logic dr,
                      input logic fl, input logic rs);
    logic exp_sr;
    @(negedge clk);
    source_valid = sv;
    source       = sd;
    drain_ready  = dr;
    flush        = fl;
    reset        = rs;
    #1;
    obs_dv = dv_a;
    obs_sr = sr_a;
    obs_da = drain_a;
    obs_db = drain_b;

    // A DEPTH-entry buffer accepts whenever it has room or is being emptied.
    exp_sr = !rs && !fl && ((exp_q_a.size() < D) || dr);
    check_eq("source_ready_a", {31'b0, sr_a}, {31'b0, exp_sr});
    check_eq("source_ready_b", {31'b0, sr_b}, {31'b0, exp_sr});
`ifdef MULT_STAGE_PIPE_OCC_EN
    if (!rs) begin
      check_eq("occupancy_a", {30'b0, occ_a}, exp_q_a.size());
      check_eq("occupancy_b", {30'b0, occ_b}, exp_q_b.size());
    end
`endif

    if (dv_a === 1'b1 && !rs) begin
      check_eq("valid_has_word_a", {31'b0, exp_q_a.size() != 0}, 32'd1);
      if (dr && exp_q_a.size() != 0)
        check_eq("drain_data_a", {24'b0, drain_a}, {24'b0, exp_q_a.pop_front() ^ {W{INV_A}}});
    end
    if (dv_b === 1'b1 && !rs) begin
      check_eq("valid_has_word_b", {31'b0, exp_q_b.size() != 0}, 32'd1);
      if (dr && exp_q_b.size() != 0)
        check_eq("drain_data_b", {24'b0, drain_b}, {24'b0, exp_q_b.pop_front() ^ {W{INV_B}}});
    end

    if (sv && exp_sr) begin
      exp_q_a.push_back(sd);
      exp_q_b.push_back(sd);
    end
    if (fl || rs) begin
      exp_q_a.delete();
      exp_q_b.delete();
    end
  endtask

  task automatic idle(input logic dr);
    step(1'b0, '0, dr, 1'b0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int first, last, cnt, acc;

    // Reset state
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);
    check_eq("reset_drain_valid", {31'b0, obs_dv}, 32'd0);
    check_eq("reset_drain_a", {24'b0, obs_da}, 32'd0);
    check_eq("reset_drain_b", {24'b0, obs_db}, 32'd0);
    check_eq("ready_after_reset", {31'b0, obs_sr}, 32'd1);

    // Single push: visible exactly DEPTH cycles later, for one cycle
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0);
    first = -1;
    cnt   = 0;
    for (int k = 1; k <= 6; k++) begin
      idle(1'b1);
      if (obs_dv === 1'b1) begin
        cnt++;
        if (first < 0) begin
          first = k;
          check_eq("single_a", {24'b0, obs_da}, 32'hA5);
          check_eq("single_b", {24'b0, obs_db}, 32'h5A);
        end
      end
    end
    check_eq("single_latency", first, D);
    check_eq("single_count", cnt, 1);

    // Back-to-back stream: one word per cycle, no gaps
    first = -1;
    last  = -1;
    cnt   = 0;
    for (int k = 0; k < 16 + D + 2; k++) begin
      if (k < 16) step(1'b1, W'(k), 1'b1, 1'b0, 1'b0);
      else        idle(1'b1);
      if (obs_dv === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
        last = k;
      end
    end
    check_eq("stream_count", cnt, 16);
    check_eq("stream_contiguous", last - first, 15);

    // Stall: only DEPTH words fit
    acc = 0;
    for (int k = 1; k <= 6; k++) begin
      step(1'b1, W'(k), 1'b0, 1'b0, 1'b0);
      if (obs_sr === 1'b1) acc++;
    end
    check_eq("stall_accepted", acc, D);
    check_eq("stall_ready_low", {31'b0, obs_sr}, 32'd0);
    // Full pipe: push and pop on the same edge
    step(1'b1, 8'h77, 1'b1, 1'b0, 1'b0);
    check_eq("full_push_pop_ready", {31'b0, obs_sr}, 32'd1);
    for (int k = 0; k < D + 2; k++) idle(1'b1);

    // Flush with two words in flight
    step(1'b1, 8'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("flush_valid", {31'b0, obs_dv}, 32'd0);
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < D + 1; k++) idle(1'b1);

    // Reset mid-stream
    step(1'b1, 8'h41, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h42, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h43, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'h44, 1'b1, 1'b0, 1'b1);
    idle(1'b1);
    check_eq("midreset_valid", {31'b0, obs_dv}, 32'd0);
    check_eq("midreset_drain", {24'b0, obs_da}, 32'd0);
    check_eq("midreset_ready", {31'b0, obs_sr}, 32'd1);

    // Randomized traffic with occasional flush
    for (int k = 0; k < 600; k++) begin
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 59) == 0), 1'b0);
    end

    // Drain everything still in flight (bounded)
    for (int k = 0; k < 4 * D && exp_q_a.size() != 0; k++) idle(1'b1);
    check_eq("final_empty_a", exp_q_a.size(), 0);
    check_eq("final_empty_b", exp_q_b.size(), 0);
    idle(1'b1);
    check_eq("final_valid", {31'b0, obs_dv}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
